// File: rtl/d_cache_pkg.sv
// Shared types and helpers for the N-way set-associative data cache.
package d_cache_pkg;

    // Controller states: idle/hit service, dirty write-back, line refill, uncached transfer.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_RF,
        ST_UC,
        ST_UC_DONE
    } state_t;

    localparam int          BYTE_OFF_W = 2;
    localparam logic [1:0]  SIZE_WORD  = 2'b10;

    // Tag width left over once index, word offset and byte offset are removed.
    function automatic int tag_width(input int index_w, input int offset_w);
        return 32 - index_w - offset_w - BYTE_OFF_W;
    endfunction

    // Replace the bytes of old_word selected by sel with those of new_word.
    function automatic logic [31:0] byte_merge(input logic [3:0]  sel,
                                               input logic [31:0] old_word,
                                               input logic [31:0] new_word);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = sel[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/d_cache_nway_if.sv
// SRAM-like data bus between the cache (master) and memory (slave).
interface d_cache_nway_if;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wen;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_wen, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_wen, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok
    );
endinterface

// File: rtl/d_cache_way.sv
// One cache way: valid/dirty bits, tags and line data for every set.
module d_cache_way
    import d_cache_pkg::*;
#(
    parameter int INDEX_W  = 7,
    parameter int OFFSET_W = 2,
    parameter int TAG_W    = tag_width(INDEX_W, OFFSET_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  index,
    // read port
    input  logic [OFFSET_W-1:0] rd_word,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [31:0]         rd_data,
    // word write port
    input  logic                wr_en,
    input  logic [OFFSET_W-1:0] wr_word,
    input  logic [3:0]          wr_mask,
    input  logic [31:0]         wr_data,
    // line metadata write port
    input  logic                meta_we,
    input  logic                meta_valid,
    input  logic                meta_dirty,
    input  logic [TAG_W-1:0]    meta_tag
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS*WORDS];

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_mem[index];
    assign rd_data  = data_mem[{index, rd_word}];

    // Line state bits: cleared by reset, updated on refill completion or store hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_we) begin
            valid_q[index] <= meta_valid;
            dirty_q[index] <= meta_dirty;
        end
    end

    // NOTE: tags and data carry no reset (valid bits alone qualify them), so they map onto RAM; writes are still blocked during reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (meta_we) tag_mem[index] <= meta_tag;
            if (wr_en) begin
                data_mem[{index, wr_word}] <= byte_merge(wr_mask, data_mem[{index, wr_word}], wr_data);
            end
        end
    end

endmodule

// File: rtl/d_cache_nway.sv
// Write-back, write-allocate, N-way set-associative data cache with uncached bypass.
module d_cache_nway
    import d_cache_pkg::*;
#(
    parameter int WAYS     = 2,
    parameter int INDEX_W  = 7,
    parameter int OFFSET_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memenM,
    input  logic               memwriteM,
    input  logic [3:0]         sel,
    input  logic [1:0]         data_sram_size,
    input  logic               uncached,
    input  logic [31:0]        data_paddr,
    input  logic [31:0]        writedata2M,
    output logic [31:0]        readdataM,
    output logic               cache_ready,
    d_cache_nway_if.master     bus
);
    localparam int TAG_W = tag_width(INDEX_W, OFFSET_W);
    localparam int SETS  = 1 << INDEX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    wire [TAG_W-1:0]    addr_tag   = data_paddr[31 -: TAG_W];
    wire [INDEX_W-1:0]  addr_index = data_paddr[OFFSET_W+2 +: INDEX_W];
    wire [OFFSET_W-1:0] addr_word  = data_paddr[2 +: OFFSET_W];

    state_t              state_q, state_d;
    logic [OFFSET_W-1:0] cnt_q;
    logic                addr_acc_q;
    logic [31:0]         uc_data_q;
    logic [WAY_W-1:0]    rr_q [SETS];

    logic                w_valid [WAYS];
    logic                w_dirty [WAYS];
    logic [TAG_W-1:0]    w_tag   [WAYS];
    logic [31:0]         w_data  [WAYS];
    logic [WAYS-1:0]     hit_vec, w_wr_en, w_meta_we;

    logic [OFFSET_W-1:0] rd_word, wr_word;
    logic [3:0]          wr_mask;
    logic [31:0]         wr_data;
    logic                meta_dirty;

    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [31:0]         hit_data;

    wire [WAY_W-1:0] victim     = rr_q[addr_index];
    wire             vict_dirty = w_valid[victim] && w_dirty[victim];
    wire             last_word  = (cnt_q == {OFFSET_W{1'b1}});
    wire             xfer_state = (state_q == ST_WB) || (state_q == ST_RF) || (state_q == ST_UC);
    wire             word_done  = xfer_state && bus.data_data_ok;
    wire             refill_end = (state_q == ST_RF) && bus.data_data_ok && last_word;
    wire [WAY_W-1:0] rr_next    = (WAYS == 1) ? '0 : victim + 1'b1;

    // The write-back walks the victim line, everything else reads the CPU's word.
    assign rd_word = (state_q == ST_WB) ? cnt_q : addr_word;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        d_cache_way #(.INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W)) u_way (
            .clk        (clk),
            .rst        (rst),
            .index      (addr_index),
            .rd_word    (rd_word),
            .rd_valid   (w_valid[g]),
            .rd_dirty   (w_dirty[g]),
            .rd_tag     (w_tag[g]),
            .rd_data    (w_data[g]),
            .wr_en      (w_wr_en[g]),
            .wr_word    (wr_word),
            .wr_mask    (wr_mask),
            .wr_data    (wr_data),
            .meta_we    (w_meta_we[g]),
            .meta_valid (1'b1),
            .meta_dirty (meta_dirty),
            .meta_tag   (addr_tag)
        );
        assign hit_vec[g] = w_valid[g] && (w_tag[g] == addr_tag);
    end

    // Hit detection: select the matching way and its word.
    always_comb begin
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) begin
                hit_way  = WAY_W'(w);
                hit_data = w_data[w];
            end
        end
        hit = (state_q == ST_IDLE) && memenM && !uncached && (|hit_vec);
    end

    // Array write steering: store hits merge bytes, refill writes whole words.
    always_comb begin
        w_wr_en    = '0;
        w_meta_we  = '0;
        wr_word    = addr_word;
        wr_mask    = sel;
        wr_data    = writedata2M;
        meta_dirty = 1'b1;
        if (hit && memwriteM) begin
            w_wr_en[hit_way]   = 1'b1;
            w_meta_we[hit_way] = 1'b1;
        end
        if ((state_q == ST_RF) && bus.data_data_ok) begin
            w_wr_en[victim] = 1'b1;
            wr_word         = cnt_q;
            wr_mask         = 4'b1111;
            wr_data         = bus.data_rdata;
            if (last_word) begin
                w_meta_we[victim] = 1'b1;
                meta_dirty        = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        cache_ready    = 1'b0;
        readdataM      = '0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_wen   = 4'b0000;
        bus.data_size  = SIZE_WORD;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (memenM) begin
                    if (uncached) begin
                        state_d = ST_UC;
                    end else if (hit) begin
                        cache_ready = 1'b1;
                        readdataM   = hit_data;
                    end else begin
                        state_d = vict_dirty ? ST_WB : ST_RF;
                    end
                end
            end
            ST_WB: begin
                bus.data_req   = !addr_acc_q;
                bus.data_wr    = 1'b1;
                bus.data_wen   = 4'b1111;
                bus.data_addr  = {w_tag[victim], addr_index, cnt_q, 2'b00};
                bus.data_wdata = w_data[victim];
                if (bus.data_data_ok && last_word) state_d = ST_RF;
            end
            ST_RF: begin
                bus.data_req  = !addr_acc_q;
                bus.data_addr = {addr_tag, addr_index, cnt_q, 2'b00};
                if (bus.data_data_ok && last_word) state_d = ST_IDLE;
            end
            ST_UC: begin
                bus.data_req   = !addr_acc_q;
                bus.data_wr    = memwriteM;
                bus.data_wen   = memwriteM ? sel : 4'b0000;
                bus.data_size  = data_sram_size;
                bus.data_addr  = data_paddr;
                bus.data_wdata = writedata2M;
                if (bus.data_data_ok) state_d = ST_UC_DONE;
            end
            ST_UC_DONE: begin
                cache_ready = 1'b1;
                readdataM   = uc_data_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus bookkeeping: address-accepted flag, line word counter, uncached read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_acc_q <= 1'b0;
            cnt_q      <= '0;
            uc_data_q  <= '0;
        end else begin
            if (word_done)                             addr_acc_q <= 1'b0;
            else if (bus.data_req && bus.data_addr_ok) addr_acc_q <= 1'b1;
            if (word_done && (state_q != ST_UC))       cnt_q      <= cnt_q + 1'b1;
            if ((state_q == ST_UC) && bus.data_data_ok) uc_data_q <= bus.data_rdata;
        end
    end

    // Per-set round-robin victim pointer, advanced only when a refill completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (refill_end) begin
            rr_q[addr_index] <= rr_next;
        end
    end

endmodule

// File: tb/tb_d_cache_nway.sv
// Self-checking bench for d_cache_nway: bus responder with scoreboard queues.
module tb_d_cache_nway;
    import d_cache_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [3:0]  wen;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM, memwriteM, uncached;
    logic [3:0]  sel;
    logic [1:0]  data_sram_size;
    logic [31:0] data_paddr, writedata2M, readdataM;
    logic        cache_ready;

    d_cache_nway_if bus ();

    d_cache_nway #(.WAYS(2), .INDEX_W(7), .OFFSET_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .memenM         (memenM),
        .memwriteM      (memwriteM),
        .sel            (sel),
        .data_sram_size (data_sram_size),
        .uncached       (uncached),
        .data_paddr     (data_paddr),
        .writedata2M    (writedata2M),
        .readdataM      (readdataM),
        .cache_ready    (cache_ready),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    bus_t        exp_bus [$];
    logic [31:0] exp_rd  [$];
    logic [31:0] mem [logic [31:0]];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          addr_delay = 0;
    int          data_delay = 0;
    bit          rst_abort_ok = 1'b0;
    int          bus_served = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic bus_t cur_bus();
        bus_t b;
        b.wr    = bus.data_wr;
        b.wen   = bus.data_wen;
        b.size  = bus.data_size;
        b.addr  = bus.data_addr;
        b.wdata = bus.data_wdata;
        return b;
    endfunction

    task automatic push_rd(input logic [31:0] a, input logic [1:0] sz);
        bus_t b;
        b = '{wr: 1'b0, wen: 4'b0000, size: sz, addr: a, wdata: 32'h0};
        exp_bus.push_back(b);
    endtask

    task automatic push_line_rd(input logic [31:0] base);
        for (int w = 0; w < 4; w++) push_rd(base + 32'(4 * w), 2'b10);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [3:0] wen, input logic [1:0] sz,
                           input logic [31:0] wd);
        bus_t b;
        b = '{wr: 1'b1, wen: wen, size: sz, addr: a, wdata: wd};
        exp_bus.push_back(b);
    endtask

    // Memory-side responder: checks each accepted transfer against the expected queue.
    task automatic serve(input bus_t obs);
        bus_t        e;
        logic [31:0] a;
        if (!obs.wr) obs.wdata = 32'h0;
        check("bus_expected", 32'(exp_bus.size() != 0), 32'd1);
        if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            check("bus_xfer", obs, e);
        end
        a = {obs.addr[31:2], 2'b00};
        if (obs.wr) mem[a] = byte_merge(obs.wen, rd_mem(a), obs.wdata);
        else        bus.data_rdata = rd_mem(a);
        bus_served++;
    endtask

    initial begin
        bus_t cap;
        bit   aborted;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            if (bus.data_req && !rst) begin
                cap     = cur_bus();
                aborted = 1'b0;
                for (int k = 0; k < addr_delay; k++) begin
                    @(negedge clk);
                    if (!bus.data_req && rst_abort_ok) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("req_stable", {bus.data_req, cur_bus()}, {1'b1, cap});
                end
                if (!aborted) begin
                    serve(cur_bus());
                    bus.data_addr_ok = 1'b1;
                    if (data_delay == 0) begin
                        bus.data_data_ok = 1'b1;
                    end else begin
                        @(negedge clk);
                        bus.data_addr_ok = 1'b0;
                        check("req_drop", bus.data_req, 1'b0);
                        for (int k = 1; k < data_delay; k++) @(negedge clk);
                        bus.data_data_ok = 1'b1;
                    end
                end
            end
        end
    end

    // One CPU access held until cache_ready; exp_cyc < 0 skips the latency check.
    task automatic access(input logic [31:0] a, input logic we, input logic [3:0] s,
                          input logic [31:0] wd, input logic uc, input logic [1:0] sz,
                          input logic [31:0] exp_data, input int exp_cyc);
        int          cyc;
        bit          got;
        logic [31:0] e;
        @(negedge clk);
        memenM = 1'b1; memwriteM = we; sel = s; writedata2M = wd;
        uncached = uc; data_sram_size = sz; data_paddr = a;
        if (!we) exp_rd.push_back(exp_data);
        cyc = 0;
        got = 1'b0;
        while (cyc < 200) begin
            #1;
            if (cache_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (!got) begin
            check("ready_timeout", 32'(cyc), 32'd0);
        end else begin
            if (!we) begin
                e = exp_rd.pop_front();
                check("rdata", readdataM, e);
            end
            if (exp_cyc >= 0) check("latency", 32'(cyc), 32'(exp_cyc));
            @(posedge clk);
            #1;
            if (uc) check("uc_ready_pulse", cache_ready, 1'b0);
        end
        @(negedge clk);
        memenM = 1'b0;
        memwriteM = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n0;
        bit seen;
        rst = 1'b1; memenM = 1'b0; memwriteM = 1'b0; sel = 4'b0; uncached = 1'b0;
        data_sram_size = 2'b10; data_paddr = '0; writedata2M = '0;
        for (int w = 0; w < 4; w++) begin
            mem[32'h0000 + 32'(4*w)] = 32'hA0 + 32'(w);
            mem[32'h0800 + 32'(4*w)] = 32'hB0 + 32'(w);
            mem[32'h2040 + 32'(4*w)] = 32'hC0 + 32'(w);
            mem[32'h3010 + 32'(4*w)] = 32'hD0 + 32'(w);
        end
        mem[32'h1000] = 32'h11; mem[32'h1004] = 32'h22;
        mem[32'h1008] = 32'h33; mem[32'h100C] = 32'h44;
        mem[32'h1FC0_0000] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req", bus.data_req, 1'b0);
        check("rst_ready", cache_ready, 1'b0);
        check("rst_rdata", readdataM, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check("idle_req", bus.data_req, 1'b0);

        // Fill set 0 with two lines, dirty the first, then evict it with 0x1000.
        push_line_rd(32'h0000);
        access(32'h0000, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'hA0, 5);
        access(32'h0004, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 2'b10, 32'h0, 0);
        push_line_rd(32'h0800);
        access(32'h0800, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'hB0, 5);
        push_wr(32'h0000, 4'hF, 2'b10, 32'hA0);
        push_wr(32'h0004, 4'hF, 2'b10, 32'hDEAD_BEEF);
        push_wr(32'h0008, 4'hF, 2'b10, 32'hA2);
        push_wr(32'h000C, 4'hF, 2'b10, 32'hA3);
        push_line_rd(32'h1000);
        access(32'h1000, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'h11, 9);
        // Pointer now 1: the clean 0x0800 line is the next victim.
        push_line_rd(32'h0000);
        access(32'h0000, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'hA0, 5);
        access(32'h0004, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'hDEAD_BEEF, 0);
        access(32'h1008, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'h33, 0);
        access(32'h1004, 1'b1, 4'b0011, 32'hAABB_CCDD, 1'b0, 2'b10, 32'h0, 0);
        access(32'h1004, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'h0000_CCDD, 0);

        // Uncached accesses bypass the arrays.
        push_wr(32'h1FC0_0002, 4'b0100, 2'b00, 32'h0077_0000);
        access(32'h1FC0_0002, 1'b1, 4'b0100, 32'h0077_0000, 1'b1, 2'b00, 32'h0, -1);
        push_rd(32'h1FC0_0000, 2'b10);
        access(32'h1FC0_0000, 1'b0, 4'h0, 32'h0, 1'b1, 2'b10, 32'h1277_5678, -1);
        push_rd(32'h1004, 2'b10);
        access(32'h1004, 1'b0, 4'h0, 32'h0, 1'b1, 2'b10, 32'h22, -1);
        access(32'h1004, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'h0000_CCDD, 0);
        access(32'h1008, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'h33, 0);

        // Slow bus: request must hold steady until accepted.
        addr_delay = 3;
        data_delay = 2;
        push_wr(32'h1FC0_0010, 4'hF, 2'b10, 32'hCAFE_F00D);
        access(32'h1FC0_0010, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b1, 2'b10, 32'h0, -1);
        push_line_rd(32'h2040);
        access(32'h2040, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'hC0, -1);
        push_rd(32'h1FC0_0010, 2'b10);
        access(32'h1FC0_0010, 1'b0, 4'h0, 32'h0, 1'b1, 2'b10, 32'hCAFE_F00D, -1);

        // Reset during the second refill word.
        addr_delay = 3;
        data_delay = 0;
        rst_abort_ok = 1'b1;
        push_rd(32'h3010, 2'b10);
        n0 = bus_served;
        @(negedge clk);
        memenM = 1'b1; memwriteM = 1'b0; uncached = 1'b0; data_sram_size = 2'b10;
        data_paddr = 32'h3010;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (bus_served > n0 && bus.data_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("rf_word1_seen", seen, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_req_drop", bus.data_req, 1'b0);
        rst = 1'b0;
        memenM = 1'b0;
        addr_delay = 0;
        @(negedge clk);
        rst_abort_ok = 1'b0;
        push_line_rd(32'h3010);
        access(32'h3010, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'hD0, 5);
        push_line_rd(32'h1000);
        access(32'h1008, 1'b0, 4'h0, 32'h0, 1'b0, 2'b10, 32'h33, 5);

        repeat (3) @(negedge clk);
        check("bus_q_empty", 32'(exp_bus.size()), 32'd0);
        check("rd_q_empty", 32'(exp_rd.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
